// File: rtl/instr_encoder_loader.sv
// Packs opcode/dest/src/imm field tuples into 16-bit instruction words and streams them through a
// small FIFO into program memory at consecutive addresses. Optional macro: INSTR_CHECKSUM_EN.
module instr_encoder_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_fmt,
  input  logic [3:0]            in_opcode,
  input  logic [3:0]            in_dest,
  input  logic [3:0]            in_src,
  input  logic [7:0]            in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  wrap_err
`ifdef INSTR_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e r_state, w_state_next;

  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PtrW:0]         r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]         w_count;
  logic                  w_full, w_empty;
  logic                  w_push, w_pop, w_start;
  logic [DATA_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_wrap_err;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_count == (PtrW+1)'(FIFO_DEPTH));
  assign w_start = start && (r_state == StIdle);
  assign w_push  = in_valid && in_ready;
  assign w_pop   = mem_we && mem_ready;

  // R-form keeps only the low nibble of the immediate below the source field.
  assign w_word = in_fmt ? {in_opcode, in_dest, in_imm}
                         : {in_opcode, in_dest, in_src, in_imm[3:0]};

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start) w_state_next = StLoad;
      end
      StLoad: begin
        in_ready = !w_full;
        mem_we   = !w_empty;
        if (in_valid && !w_full && in_last) w_state_next = StDrain;
      end
      StDrain: begin
        mem_we = !w_empty;
        if (w_empty || (w_pop && w_count == (PtrW+1)'(1))) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr[PtrW-1:0]] <= w_word;
        r_wr_ptr                   <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign mem_wdata = r_fifo[r_rd_ptr[PtrW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_addr   <= '0;
      r_word_count <= '0;
      r_wrap_err   <= 1'b0;
    end else if (w_start) begin
      r_mem_addr   <= base_addr;
      r_word_count <= '0;
      r_wrap_err   <= 1'b0;
    end else if (w_pop) begin
      r_mem_addr   <= r_mem_addr + 1'b1;
      r_word_count <= r_word_count + 1'b1;
      if (r_mem_addr == {ADDR_WIDTH{1'b1}}) r_wrap_err <= 1'b1;
    end
  end

  assign mem_addr   = r_mem_addr;
  assign word_count = r_word_count;
  assign wrap_err   = r_wrap_err;

`ifdef INSTR_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_checksum <= '0;
    else if (w_start) r_checksum <= '0;
    else if (w_pop)   r_checksum <= r_checksum ^ mem_wdata[15:0];
  end

  assign checksum = r_checksum;
`endif

endmodule
